imem_boot_loader: RTL and testbench

Sequences program loading into the 64-word instruction memory, which gets a synchronous write port for this purpose. It accepts a little-endian byte stream over a valid/ready handshake and assembles 32-bit words. It writes each word to consecutive word addresses from a programmable start, and holds the CPU in stall for the whole load. It sits between the boot/debug link and the instruction memory write port, beside the PC/fetch path.

---
 rtl/imem_boot_loader_pkg.sv | 8 +
 rtl/imem_word_packer.sv | 30 +++
 rtl/imem_boot_loader.sv | 90 +++++++++
 tb/tb_imem_boot_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared sizes and FSM encoding for the instruction-memory boot loader
package imem_boot_loader_pkg;
    localparam int DEPTH = 64;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ABORT} state_t;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles a little-endian byte stream into 32-bit words
module imem_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);
    localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);
    logic [1:0]  cnt;
    logic [23:0] acc;
    // word is the complete word only while the final byte is on byte_data
    assign word = {byte_data, acc};
    assign word_valid = byte_en && cnt == LAST;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (clear) begin
            cnt <= '0;
            acc <= '0;
        end else if (byte_en) begin
            cnt <= cnt + 2'd1;
            acc <= {byte_data, acc[23:8]};
        end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams bytes into consecutive imem words while stalling the CPU
module imem_boot_loader
    import imem_boot_loader_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic [AW-1:0] load_base,
    input  logic [CW-1:0] load_len,
    input  logic          load_abort,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_stall,
    output logic          load_busy,
    output logic          load_done,
    output logic          load_err
);
    state_t        state;
    logic [AW-1:0] base;
    logic [CW-1:0] len, word_cnt;
    logic          we_q, word_valid;
    logic [31:0]   word;
    imem_word_packer u_packer (
        .clk(clk), .rst(rst), .clear(state != RECV || load_abort),
        .byte_en(byte_valid && byte_ready), .byte_data(byte_data),
        .word(word), .word_valid(word_valid)
    );
    // an abort during the WRITE cycle must still cancel that write
    assign mem_we = we_q && !load_abort;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            base <= '0;
            len <= '0;
            word_cnt <= '0;
            we_q <= 1'b0;
            byte_ready <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            cpu_stall <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err <= 1'b0;
        end else begin
            we_q <= 1'b0;
            load_done <= 1'b0;
            load_err <= 1'b0;
            case (state)
                IDLE: if (load_start) begin
                    base <= load_base;
                    len <= load_len;
                    word_cnt <= '0;
                    cpu_stall <= 1'b1;
                    load_busy <= 1'b1;
                    state <= load_len == '0 ? DONE : RECV;
                    load_done <= load_len == '0;
                    byte_ready <= load_len != '0;
                end
                RECV, WRITE: if (load_abort) begin
                    state <= ABORT;
                    load_err <= 1'b1;
                    byte_ready <= 1'b0;
                end else if (state == RECV) begin
                    if (word_valid) begin
                        state <= WRITE;
                        byte_ready <= 1'b0;
                        we_q <= 1'b1;
                        mem_waddr <= base + word_cnt[AW-1:0];
                        mem_wdata <= word;
                    end
                end else if (word_cnt == len - CW'(1)) begin
                    state <= DONE;
                    load_done <= 1'b1;
                end else begin
                    state <= RECV;
                    byte_ready <= 1'b1;
                    word_cnt <= word_cnt + CW'(1);
                end
                default: begin
                    state <= IDLE;
                    cpu_stall <= 1'b0;
                    load_busy <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized self-checking bench against a word/address list model
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;
    logic          clk = 0, rst = 0, load_start = 0, load_abort = 0, byte_valid = 0;
    logic [AW-1:0] load_base = '0;
    logic [CW-1:0] load_len = '0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready, mem_we, cpu_stall, load_busy, load_done, load_err;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    int tests = 0, fails = 0, cyc = 0, n_done = 0, n_err = 0, n_stall = 0;
    int done_cyc = 0, rise_cyc = 0, viol = 0;
    int start_cyc, last_acc, w0, d0, e0, s0;
    logic          prev_stall = 0;
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];
    logic [7:0]    bq[$];

    always #5 clk = ~clk;

    imem_boot_loader dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
        .load_len(load_len), .load_abort(load_abort), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .cpu_stall(cpu_stall),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_waddr);
            wd.push_back(mem_wdata);
        end
        if (load_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (load_err) n_err++;
        if (cpu_stall) n_stall++;
        if (cpu_stall && !prev_stall) rise_cyc = cyc;
        prev_stall = cpu_stall;
        if (cpu_stall !== load_busy || (byte_ready && (mem_we || load_done || load_err || !load_busy))) viol++;
    end

    function automatic logic [31:0] exp_word(input int w);
        return {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]};
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int base, input int w);
        return AW'((base + w) % DEPTH);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_bq(input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
    endtask

    // mode 0: valid held, 1: toggling, 2: random; abort_at: byte index to abort at (-1 none)
    task automatic run_load(input int base, input int len, input int mode, input int abort_at, input int extra);
        int idx, g;
        logic hs;
        w0 = wa.size(); d0 = n_done; e0 = n_err; s0 = n_stall;
        load_base = AW'(base); load_len = CW'(len); load_start = 1; start_cyc = cyc;
        step;
        load_start = 0;
        idx = 0; g = 0; last_acc = 0;
        while (idx < bq.size() && g < 4000) begin
            byte_valid = mode == 0 ? 1'b1 : mode == 1 ? (g % 2 == 0) : 1'($urandom_range(0, 1));
            byte_data = bq[idx];
            load_abort = (idx == abort_at);
            if (extra != 0 && g == 3) begin
                load_start = 1; load_base = AW'(base + 7); load_len = CW'(len + 3);
            end
            hs = byte_valid && byte_ready;
            if (hs) last_acc = cyc;
            step;
            load_start = 0;
            if (load_abort) break;
            if (hs) idx++;
            g++;
        end
        byte_valid = 0; load_abort = 0;
        g = 0;
        while (load_busy && g < 300) begin
            step;
            g++;
        end
        tests++;
        if (load_busy) begin
            fails++;
            $display("FAIL load_timeout: load_busy=%b after bound, want 0", load_busy);
        end
    endtask

    task automatic test_reset;
        #2 rst = 1;
        #1;
        tests++;
        if ({byte_ready, mem_we, cpu_stall, load_busy, load_done, load_err, mem_waddr, mem_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got ready=%b we=%b stall=%b busy=%b done=%b err=%b addr=%0d data=%h, want all 0",
                     byte_ready, mem_we, cpu_stall, load_busy, load_done, load_err, mem_waddr, mem_wdata);
        end
        step; step;
        rst = 0;
        step;
        tests++;
        if ({byte_ready, mem_we, cpu_stall, load_busy} !== 4'b0) begin
            fails++;
            $display("FAIL reset_idle: got ready=%b we=%b stall=%b busy=%b, want 0000", byte_ready, mem_we, cpu_stall, load_busy);
        end
    endtask

    task automatic test_basic;
        bq = {8'h33, 8'h70, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
        run_load(0, 2, 0, -1, 0);
        tests++;
        if (wa.size() - w0 != 2 || wa[w0] !== 6'd0 || wd[w0] !== 32'h00007033 || wa[w0+1] !== 6'd1 || wd[w0+1] !== 32'h00100513) begin
            fails++;
            $display("FAIL basic_words: got %0d writes @%0d=%h @%0d=%h, want @0=00007033 @1=00100513",
                     wa.size() - w0, wa[w0], wd[w0], wa[w0+1], wd[w0+1]);
        end
        tests++;
        if (done_cyc != last_acc + 2 || n_done - d0 != 1 || n_err != e0) begin
            fail_latency: begin
                fails++;
                $display("FAIL basic_done: got done at %0d (count %0d, err %0d), want %0d count 1 err 0",
                         done_cyc, n_done - d0, n_err - e0, last_acc + 2);
            end
        end
        tests++;
        if (rise_cyc != start_cyc + 1 || n_stall - s0 != done_cyc - start_cyc) begin
            fails++;
            $display("FAIL basic_stall: got rise %0d len %0d, want rise %0d len %0d",
                     rise_cyc, n_stall - s0, start_cyc + 1, done_cyc - start_cyc);
        end
    endtask

    task automatic test_toggle;
        bq = {8'h33, 8'h70, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
        run_load(0, 2, 1, -1, 0);
        tests++;
        if (wa.size() - w0 != 2 || wa[w0] !== 6'd0 || wd[w0] !== 32'h00007033 || wa[w0+1] !== 6'd1 || wd[w0+1] !== 32'h00100513 || n_done - d0 != 1) begin
            fails++;
            $display("FAIL toggle_words: got %0d writes @%0d=%h @%0d=%h done %0d, want 2 writes @0=00007033 @1=00100513 done 1",
                     wa.size() - w0, wa[w0], wd[w0], wa[w0+1], wd[w0+1], n_done - d0);
        end
    endtask

    task automatic test_wrap;
        fill_bq(16);
        run_load(62, 4, 2, -1, 0);
        tests++;
        if (wa.size() - w0 != 4) begin
            fails++;
            $display("FAIL wrap_count: got %0d writes, want 4", wa.size() - w0);
        end
        for (int w = 0; w < 4; w++) begin
            tests++;
            if (w0 + w >= wa.size() || wa[w0+w] !== exp_addr(62, w) || wd[w0+w] !== exp_word(w)) begin
                fails++;
                $display("FAIL wrap_word%0d: got @%0d=%h, want @%0d=%h", w, wa[w0+w], wd[w0+w], exp_addr(62, w), exp_word(w));
            end
        end
    endtask

    task automatic test_zero_len;
        bq.delete();
        run_load(9, 0, 0, -1, 0);
        tests++;
        if (wa.size() != w0 || n_done - d0 != 1 || done_cyc != start_cyc + 1 || n_stall - s0 != 1) begin
            fails++;
            $display("FAIL zero_len: got writes %0d done %0d at +%0d stall %0d, want 0 1 +1 1",
                     wa.size() - w0, n_done - d0, done_cyc - start_cyc, n_stall - s0);
        end
    endtask

    task automatic test_abort;
        int ab[3] = '{6, 3, 4};
        int ew;
        for (int i = 0; i < 3; i++) begin
            fill_bq(12);
            run_load(int'($urandom_range(0, 63)), 3, 0, ab[i], 0);
            ew = (ab[i] % 4 == 0 && ab[i] > 0) ? ab[i] / 4 - 1 : ab[i] / 4;
            tests++;
            if (wa.size() - w0 != ew || n_err - e0 != 1 || n_done != d0) begin
                fails++;
                $display("FAIL abort_at%0d: got writes %0d err %0d done %0d, want %0d 1 0",
                         ab[i], wa.size() - w0, n_err - e0, n_done - d0, ew);
            end
        end
        fill_bq(4);
        run_load(20, 1, 0, -1, 0);
        tests++;
        if (wa.size() - w0 != 1 || wa[w0] !== 6'd20 || wd[w0] !== exp_word(0) || n_done - d0 != 1) begin
            fails++;
            $display("FAIL abort_reload: got %0d writes @%0d=%h done %0d, want 1 @20=%h done 1",
                     wa.size() - w0, wa[w0], wd[w0], n_done - d0, exp_word(0));
        end
    endtask

    task automatic test_async_reset;
        fill_bq(8);
        d0 = n_done; e0 = n_err;
        load_base = 5; load_len = 2; load_start = 1;
        step;
        load_start = 0; byte_valid = 1; byte_data = bq[0];
        step;
        byte_data = bq[1];
        step;
        byte_valid = 0;
        #2 rst = 1;
        #1;
        tests++;
        if ({byte_ready, mem_we, cpu_stall, load_busy, load_done, load_err, mem_waddr, mem_wdata} !== '0) begin
            fails++;
            $display("FAIL async_reset: got ready=%b we=%b stall=%b busy=%b addr=%0d data=%h, want all 0",
                     byte_ready, mem_we, cpu_stall, load_busy, mem_waddr, mem_wdata);
        end
        step;
        rst = 0;
        step;
        tests++;
        if (n_done != d0 || n_err != e0) begin
            fails++;
            $display("FAIL reset_pulses: got done %0d err %0d, want 0 0", n_done - d0, n_err - e0);
        end
        fill_bq(8);
        run_load(5, 2, 2, -1, 0);
        tests++;
        if (wa.size() - w0 != 2 || wa[w0] !== 6'd5 || wd[w0] !== exp_word(0) || wa[w0+1] !== 6'd6 || wd[w0+1] !== exp_word(1)) begin
            fails++;
            $display("FAIL post_reset_load: got %0d writes @%0d=%h @%0d=%h, want @5=%h @6=%h",
                     wa.size() - w0, wa[w0], wd[w0], wa[w0+1], wd[w0+1], exp_word(0), exp_word(1));
        end
    endtask

    task automatic test_start_busy;
        fill_bq(8);
        run_load(40, 2, 0, -1, 1);
        tests++;
        if (wa.size() - w0 != 2 || wa[w0] !== 6'd40 || wd[w0] !== exp_word(0) || wa[w0+1] !== 6'd41 || wd[w0+1] !== exp_word(1) || n_done - d0 != 1) begin
            fails++;
            $display("FAIL start_busy: got %0d writes @%0d=%h @%0d=%h done %0d, want @40=%h @41=%h done 1",
                     wa.size() - w0, wa[w0], wd[w0], wa[w0+1], wd[w0+1], n_done - d0, exp_word(0), exp_word(1));
        end
    endtask

    task automatic test_random;
        int base, len, bad;
        for (int it = 0; it < 8; it++) begin
            base = int'($urandom_range(0, 63));
            len = it == 0 ? DEPTH : int'($urandom_range(1, 8));
            fill_bq(4 * len);
            run_load(base, len, 2, -1, 0);
            bad = 0;
            for (int w = 0; w < len; w++)
                if (w0 + w >= wa.size() || wa[w0+w] !== exp_addr(base, w) || wd[w0+w] !== exp_word(w)) bad++;
            tests++;
            if (bad != 0 || wa.size() - w0 != len || n_done - d0 != 1 || done_cyc != last_acc + 2) begin
                fails++;
                $display("FAIL random%0d: base %0d len %0d: %0d bad words, %0d writes, done %0d at %0d, want 0 bad, %0d writes, done 1 at %0d",
                         it, base, len, bad, wa.size() - w0, n_done - d0, done_cyc, len, last_acc + 2);
            end
        end
    endtask

    task automatic test_protocol;
        tests++;
        if (viol != 0) begin
            fails++;
            $display("FAIL protocol: got %0d cycles with ready/stall/busy inconsistency, want 0", viol);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_toggle;
        test_wrap;
        test_zero_len;
        test_abort;
        test_async_reset;
        test_start_busy;
        test_random;
        test_protocol;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
